// File: rtl/sv32_tlb_array_pkg.sv
// Shared Sv32 translation types: PTE layout, TLB entry and per-instance TLB geometry.
package sv32_tlb_array_pkg;

  localparam int VPN_WIDTH  = 20;
  localparam int VPN1_WIDTH = 10;
  localparam int VPN0_WIDTH = 10;
  localparam int ASID_WIDTH = 9;
  localparam int PPN1_WIDTH = 12;
  localparam int PPN0_WIDTH = 10;

  typedef struct packed {
    logic [PPN1_WIDTH-1:0] ppn1;
    logic [PPN0_WIDTH-1:0] ppn0;
    logic [1:0]            rsw;
    logic                  d;
    logic                  a;
    logic                  g;
    logic                  u;
    logic                  x;
    logic                  w;
    logic                  r;
    logic                  v;
  } pte_t;

  // Tag is held at full VPN width; bits above an instance's tag width stay zero.
  typedef struct packed {
    logic                  v;
    logic [VPN_WIDTH-1:0]  tag;
    logic [ASID_WIDTH-1:0] asid;
    pte_t                  pte;
  } tlb_entry_t;

  typedef enum logic {
    FLUSH_IDLE,
    FLUSH_WALK
  } flush_state_e;

  localparam int ITLB_4K_ENTRIES = 16;
  localparam int ITLB_4K_ASSOC   = 4;
  localparam int ITLB_4M_ENTRIES = 4;
  localparam int ITLB_4M_ASSOC   = 2;
  localparam int DTLB_4K_ENTRIES = 32;
  localparam int DTLB_4K_ASSOC   = 4;
  localparam int DTLB_4M_ENTRIES = 8;
  localparam int DTLB_4M_ASSOC   = 2;

endpackage

// File: rtl/sv32_tlb_array_plru_tree.sv
// Tree pseudo-LRU for one set: a node bit of 1 means the colder half is the upper-index subtree.
module plru_tree #(
  parameter int ASSOC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     touch_en,
  input  logic [$clog2(ASSOC)-1:0] touch_way,
  output logic [$clog2(ASSOC)-1:0] victim
);

  localparam int LEVELS = $clog2(ASSOC);
  localparam int NODES  = ASSOC - 1;

  logic [NODES-1:0] state_q, state_d;

  always_comb begin
    int               node;
    logic [NODES-1:0] sh;
    node = 0;
    sh   = '0;
    for (int l = 0; l < LEVELS; l++) begin
      sh   = state_q >> node;
      node = 2 * node + (sh[0] ? 2 : 1);
    end
    victim = LEVELS'(node - NODES);
  end

  // Walking the touched way's path, every node is pointed at the sibling subtree.
  always_comb begin
    int                  node;
    logic [LEVELS-1:0]   wsh;
    logic [NODES-1:0]    mask;
    state_d = state_q;
    node    = 0;
    wsh     = '0;
    mask    = '0;
    if (touch_en) begin
      for (int l = 0; l < LEVELS; l++) begin
        wsh  = touch_way >> (LEVELS - 1 - l);
        mask = NODES'(1) << node;
        if (wsh[0]) state_d = state_d & ~mask;
        else        state_d = state_d | mask;
        node = 2 * node + (wsh[0] ? 2 : 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/sv32_tlb_array.sv
// Set-associative Sv32 TLB array: registered lookup, fill with PLRU replacement,
// and a set-by-set SFENCE.VMA walk filtered by ASID and/or VA.
module sv32_tlb_array
  import sv32_tlb_array_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int ASSOC       = 4,
  parameter int SUPERPAGE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VPN_WIDTH-1:0]  req_vpn,
  input  logic [ASID_WIDTH-1:0] req_asid,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output pte_t                  resp_pte,
  input  logic                  fill_valid,
  input  logic [VPN_WIDTH-1:0]  fill_vpn,
  input  logic [ASID_WIDTH-1:0] fill_asid,
  input  pte_t                  fill_pte,
  input  logic                  flush_valid,
  output logic                  flush_ready,
  input  logic                  flush_asid_en,
  input  logic [ASID_WIDTH-1:0] flush_asid,
  input  logic                  flush_va_en,
  input  logic [VPN_WIDTH-1:0]  flush_vpn
);

  localparam int NUM_SETS    = NUM_ENTRIES / ASSOC;
  localparam int SET_BITS    = $clog2(NUM_SETS);
  localparam int INDEX_WIDTH = (SET_BITS < 1) ? 1 : SET_BITS;
  localparam int TAG_WIDTH   = ((SUPERPAGE != 0) ? VPN1_WIDTH : VPN_WIDTH) - SET_BITS;
  localparam int WAY_W       = $clog2(ASSOC);
  localparam logic [VPN_WIDTH-1:0] SET_MASK = VPN_WIDTH'(NUM_SETS - 1);
  localparam logic [VPN_WIDTH-1:0] TAG_MASK = VPN_WIDTH'((1 << TAG_WIDTH) - 1);

  function automatic logic [VPN_WIDTH-1:0] page_bits(logic [VPN_WIDTH-1:0] vpn);
    return (SUPERPAGE != 0) ? (vpn >> VPN0_WIDTH) : vpn;
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] idx_of(logic [VPN_WIDTH-1:0] vpn);
    logic [VPN_WIDTH-1:0] m;
    m = page_bits(vpn) & SET_MASK;
    return INDEX_WIDTH'(m);
  endfunction

  function automatic logic [VPN_WIDTH-1:0] tag_of(logic [VPN_WIDTH-1:0] vpn);
    return (page_bits(vpn) >> SET_BITS) & TAG_MASK;
  endfunction

  function automatic logic entry_match(tlb_entry_t e, logic [VPN_WIDTH-1:0] tag,
                                       logic [ASID_WIDTH-1:0] asid);
    return e.v && (e.tag == tag) && (e.pte.g || (e.asid == asid));
  endfunction

  tlb_entry_t entries_q [NUM_SETS][ASSOC];
  logic [WAY_W-1:0] victim [NUM_SETS];

  flush_state_e          state_q, state_d;
  logic [INDEX_WIDTH-1:0] cnt_q;
  logic                  asid_en_q, va_en_q;
  logic [ASID_WIDTH-1:0] fasid_q;
  logic [VPN_WIDTH-1:0]  ftag_q;
  logic                  walk_last;
  logic [ASSOC-1:0]      clr;

  logic                  req_fire, fill_do;
  logic [INDEX_WIDTH-1:0] lk_idx, fl_idx;
  logic [VPN_WIDTH-1:0]  lk_tag, fl_tag;
  logic                  lk_hit;
  logic [WAY_W-1:0]      lk_way;
  pte_t                  lk_pte;
  logic                  fl_match, fl_free;
  logic [WAY_W-1:0]      fl_match_way, fl_free_way, fill_way;
  tlb_entry_t            fill_entry;

  logic                  resp_valid_q, resp_hit_q;
  pte_t                  resp_pte_q;
  logic [INDEX_WIDTH-1:0] resp_set_q;
  logic [WAY_W-1:0]      resp_way_q;

  assign req_ready   = (state_q == FLUSH_IDLE);
  assign flush_ready = (state_q == FLUSH_IDLE);
  assign req_fire    = req_valid && req_ready;
  assign fill_do     = fill_valid && (state_q == FLUSH_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_pte    = resp_pte_q;

  // Descending scans leave the lowest matching way selected.
  always_comb begin
    lk_idx = idx_of(req_vpn);
    lk_tag = tag_of(req_vpn);
    lk_hit = 1'b0;
    lk_way = '0;
    lk_pte = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (entry_match(entries_q[lk_idx][w], lk_tag, req_asid)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
        lk_pte = entries_q[lk_idx][w].pte;
      end
    end
    if ((SUPERPAGE != 0) && lk_hit) lk_pte.ppn0 = req_vpn[VPN0_WIDTH-1:0];
  end

  always_comb begin
    fl_idx       = idx_of(fill_vpn);
    fl_tag       = tag_of(fill_vpn);
    fl_match     = 1'b0;
    fl_match_way = '0;
    fl_free      = 1'b0;
    fl_free_way  = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (entry_match(entries_q[fl_idx][w], fl_tag, fill_asid)) begin
        fl_match     = 1'b1;
        fl_match_way = WAY_W'(w);
      end
      if (!entries_q[fl_idx][w].v) begin
        fl_free     = 1'b1;
        fl_free_way = WAY_W'(w);
      end
    end
    fill_way = fl_match ? fl_match_way : (fl_free ? fl_free_way : victim[fl_idx]);
    fill_entry      = '0;
    fill_entry.v    = 1'b1;
    fill_entry.tag  = fl_tag;
    fill_entry.asid = fill_asid;
    fill_entry.pte  = fill_pte;
    if (SUPERPAGE != 0) fill_entry.pte.ppn0 = '0;
  end

  always_comb begin
    state_d   = state_q;
    walk_last = va_en_q || (cnt_q == INDEX_WIDTH'(NUM_SETS - 1));
    clr       = '0;
    case (state_q)
      FLUSH_IDLE: if (flush_valid) state_d = FLUSH_WALK;
      FLUSH_WALK: if (walk_last)   state_d = FLUSH_IDLE;
      default:                     state_d = FLUSH_IDLE;
    endcase
    if (state_q == FLUSH_WALK) begin
      for (int w = 0; w < ASSOC; w++) begin
        clr[w] = entries_q[cnt_q][w].v
               && (!asid_en_q || ((entries_q[cnt_q][w].asid == fasid_q) && !entries_q[cnt_q][w].pte.g))
               && (!va_en_q || (entries_q[cnt_q][w].tag == ftag_q));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FLUSH_IDLE;
      cnt_q     <= '0;
      asid_en_q <= 1'b0;
      va_en_q   <= 1'b0;
      fasid_q   <= '0;
      ftag_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FLUSH_IDLE && flush_valid) begin
        cnt_q     <= flush_va_en ? idx_of(flush_vpn) : '0;
        asid_en_q <= flush_asid_en;
        va_en_q   <= flush_va_en;
        fasid_q   <= flush_asid;
        ftag_q    <= tag_of(flush_vpn);
      end else if (state_q == FLUSH_WALK) begin
        cnt_q <= cnt_q + INDEX_WIDTH'(1);
      end
    end
  end

  // Fills only happen while idle and clears only while walking, so the two never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < ASSOC; w++)
          entries_q[s][w] <= '0;
    end else begin
      if (fill_do) entries_q[fl_idx][fill_way] <= fill_entry;
      for (int w = 0; w < ASSOC; w++)
        if (clr[w]) entries_q[cnt_q][w].v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_pte_q   <= '0;
      resp_set_q   <= '0;
      resp_way_q   <= '0;
    end else begin
      resp_valid_q <= req_fire;
      resp_hit_q   <= req_fire && lk_hit;
      resp_pte_q   <= req_fire ? lk_pte : '0;
      resp_set_q   <= lk_idx;
      resp_way_q   <= lk_way;
    end
  end

  // A hit is credited to PLRU in its response cycle unless a fill lands in the same set.
  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    logic             touch_en;
    logic [WAY_W-1:0] touch_way;

    always_comb begin
      touch_en  = 1'b0;
      touch_way = resp_way_q;
      if (fill_do && (fl_idx == INDEX_WIDTH'(s))) begin
        touch_en  = 1'b1;
        touch_way = fill_way;
      end else if (resp_valid_q && resp_hit_q && (resp_set_q == INDEX_WIDTH'(s))) begin
        touch_en  = 1'b1;
      end
    end

    plru_tree #(.ASSOC(ASSOC)) u_plru (
      .clk      (clk),
      .rst_n    (rst_n),
      .touch_en (touch_en),
      .touch_way(touch_way),
      .victim   (victim[s])
    );
  end

endmodule

// File: tb/tb_sv32_tlb_array.sv
// Directed bench for sv32_tlb_array: a default 4KB instance and a small 4MB-page instance.
module tb_sv32_tlb_array;
  import sv32_tlb_array_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [19:0] req_vpn = '0;
  logic [8:0]  req_asid = '0;
  logic        resp_valid, resp_hit;
  pte_t        resp_pte;
  logic        fill_valid = 1'b0;
  logic [19:0] fill_vpn = '0;
  logic [8:0]  fill_asid = '0;
  pte_t        fill_pte = '0;
  logic        flush_valid = 1'b0;
  logic        flush_ready;
  logic        flush_asid_en = 1'b0;
  logic [8:0]  flush_asid = '0;
  logic        flush_va_en = 1'b0;
  logic [19:0] flush_vpn = '0;

  logic        sp_req_valid = 1'b0;
  logic        sp_req_ready;
  logic [19:0] sp_req_vpn = '0;
  logic        sp_resp_valid, sp_resp_hit;
  pte_t        sp_resp_pte;
  logic        sp_fill_valid = 1'b0;
  logic [19:0] sp_fill_vpn = '0;
  pte_t        sp_fill_pte = '0;
  logic        sp_flush_ready;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sv32_tlb_array #(.NUM_ENTRIES(16), .ASSOC(4), .SUPERPAGE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn), .req_asid(req_asid),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_pte(resp_pte),
    .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_asid(fill_asid), .fill_pte(fill_pte),
    .flush_valid(flush_valid), .flush_ready(flush_ready),
    .flush_asid_en(flush_asid_en), .flush_asid(flush_asid),
    .flush_va_en(flush_va_en), .flush_vpn(flush_vpn)
  );

  sv32_tlb_array #(.NUM_ENTRIES(4), .ASSOC(2), .SUPERPAGE(1)) dut_sp (
    .clk(clk), .rst_n(rst_n),
    .req_valid(sp_req_valid), .req_ready(sp_req_ready), .req_vpn(sp_req_vpn), .req_asid(9'd0),
    .resp_valid(sp_resp_valid), .resp_hit(sp_resp_hit), .resp_pte(sp_resp_pte),
    .fill_valid(sp_fill_valid), .fill_vpn(sp_fill_vpn), .fill_asid(9'd0), .fill_pte(sp_fill_pte),
    .flush_valid(1'b0), .flush_ready(sp_flush_ready),
    .flush_asid_en(1'b0), .flush_asid(9'd0),
    .flush_va_en(1'b0), .flush_vpn(20'd0)
  );

  function automatic pte_t mk_pte(logic [21:0] ppn, logic g);
    pte_t p;
    p = '0;
    p.ppn1 = ppn[21:10];
    p.ppn0 = ppn[9:0];
    p.g = g;
    p.v = 1'b1;
    p.r = 1'b1;
    p.x = 1'b1;
    p.a = 1'b1;
    return p;
  endfunction

  task automatic do_lookup(input logic [19:0] vpn, input logic [8:0] asid,
                           output logic valid, output logic hit, output pte_t pte);
    @(negedge clk);
    req_valid = 1'b1; req_vpn = vpn; req_asid = asid;
    @(negedge clk);
    req_valid = 1'b0;
    valid = resp_valid; hit = resp_hit; pte = resp_pte;
  endtask

  task automatic do_fill(input logic [19:0] vpn, input logic [8:0] asid, input pte_t pte);
    @(negedge clk);
    fill_valid = 1'b1; fill_vpn = vpn; fill_asid = asid; fill_pte = pte;
    @(negedge clk);
    fill_valid = 1'b0;
  endtask

  // Starts a flush (optionally with a same-cycle lookup and a fill in the first walk cycle)
  // and counts the cycles req_ready stays low.
  task automatic do_flush(input logic aen, input logic [8:0] asid, input logic ven,
                          input logic [19:0] vpn, input logic with_fill, input logic with_req,
                          input logic [19:0] rvpn, input logic [8:0] rasid,
                          output int cycles, output logic busy, output logic rhit);
    @(negedge clk);
    flush_valid = 1'b1; flush_asid_en = aen; flush_asid = asid;
    flush_va_en = ven; flush_vpn = vpn;
    if (with_req) begin
      req_valid = 1'b1; req_vpn = rvpn; req_asid = rasid;
    end
    @(negedge clk);
    flush_valid = 1'b0; req_valid = 1'b0;
    rhit = resp_hit;
    busy = (req_ready === 1'b0) && (flush_ready === 1'b0);
    if (with_fill) begin
      fill_valid = 1'b1; fill_vpn = 20'h00303; fill_asid = 9'd5; fill_pte = mk_pte(22'h00303, 1'b0);
    end
    cycles = 0;
    while (req_ready === 1'b0 && cycles < 50) begin
      cycles++;
      @(negedge clk);
      fill_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    tests_run++; if (flush_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_flush_ready: got %b expected 1", flush_ready); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    tests_run++; if (resp_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp_hit: got %b expected 0", resp_hit); end
    tests_run++; if (resp_pte !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_resp_pte: got %h expected 0", resp_pte); end
  endtask

  task automatic test_basic();
    logic v, h; pte_t p;
    do_lookup(20'h12345, 9'd3, v, h, p);
    tests_run++; if (v !== 1'b1 || h !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_cold_miss: got valid=%b hit=%b expected valid=1 hit=0", v, h); end
    do_fill(20'h12345, 9'd3, mk_pte(22'h2ABCD, 1'b0));
    do_lookup(20'h12345, 9'd3, v, h, p);
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_hit: got %b expected 1", h); end
    tests_run++; if ({p.ppn1, p.ppn0} !== 22'h2ABCD) begin tests_failed++; $display("[TB] FAIL basic_ppn: got %h expected 2abcd", {p.ppn1, p.ppn0}); end
    @(negedge clk);
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_valid_drop: got %b expected 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic v, h; pte_t p;
    @(negedge clk);
    req_valid = 1'b1; req_vpn = 20'h0ABCD; req_asid = 9'd3;
    fill_valid = 1'b1; fill_vpn = 20'h0ABCD; fill_asid = 9'd3; fill_pte = mk_pte(22'h00777, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; fill_valid = 1'b0;
    tests_run++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_same_cycle_fill: got valid=%b hit=%b expected valid=1 hit=0", resp_valid, resp_hit); end
    do_lookup(20'h0ABCD, 9'd3, v, h, p);
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_next_hit: got %b expected 1", h); end
    tests_run++; if ({p.ppn1, p.ppn0} !== 22'h00777) begin tests_failed++; $display("[TB] FAIL b2b_ppn: got %h expected 00777", {p.ppn1, p.ppn0}); end
  endtask

  task automatic test_plru();
    logic v, h; pte_t p;
    logic [19:0] vpns [5];
    logic exp_hit [5];
    vpns = '{20'h00004, 20'h00014, 20'h00024, 20'h00034, 20'h00044};
    exp_hit = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) do_fill(vpns[i], 9'd2, mk_pte(22'h00100 + 22'(i), 1'b0));
    do_lookup(vpns[0], 9'd2, v, h, p);
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("[TB] FAIL plru_touch_hit: got %b expected 1", h); end
    do_fill(vpns[4], 9'd2, mk_pte(22'h00104, 1'b0));
    for (int i = 0; i < 5; i++) begin
      do_lookup(vpns[i], 9'd2, v, h, p);
      tests_run++; if (h !== exp_hit[i]) begin tests_failed++; $display("[TB] FAIL plru_evict vpn=%h: got hit=%b expected %b", vpns[i], h, exp_hit[i]); end
    end
  endtask

  task automatic test_global();
    logic v, h; pte_t p;
    do_fill(20'h00101, 9'd1, mk_pte(22'h00101, 1'b1));
    do_fill(20'h00202, 9'd1, mk_pte(22'h00202, 1'b0));
    do_lookup(20'h00101, 9'd7, v, h, p);
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("[TB] FAIL global_other_asid: got %b expected 1", h); end
    do_lookup(20'h00202, 9'd7, v, h, p);
    tests_run++; if (h !== 1'b0) begin tests_failed++; $display("[TB] FAIL nonglobal_other_asid: got %b expected 0", h); end
    do_lookup(20'h00202, 9'd1, v, h, p);
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("[TB] FAIL nonglobal_own_asid: got %b expected 1", h); end
  endtask

  task automatic test_refill();
    logic v, h; pte_t p;
    do_fill(20'h0ABCD, 9'd3, mk_pte(22'h11111, 1'b0));
    do_lookup(20'h0ABCD, 9'd3, v, h, p);
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("[TB] FAIL refill_hit: got %b expected 1", h); end
    tests_run++; if ({p.ppn1, p.ppn0} !== 22'h11111) begin tests_failed++; $display("[TB] FAIL refill_ppn: got %h expected 11111", {p.ppn1, p.ppn0}); end
  endtask

  task automatic test_flush_asid();
    logic v, h, busy, rh; pte_t p; int cyc;
    do_flush(1'b1, 9'd1, 1'b0, 20'h0, 1'b1, 1'b0, 20'h0, 9'd0, cyc, busy, rh);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_asid_busy: got %b expected 1", busy); end
    tests_run++; if (cyc != 4) begin tests_failed++; $display("[TB] FAIL flush_asid_cycles: got %0d expected 4", cyc); end
    do_lookup(20'h00202, 9'd1, v, h, p);
    tests_run++; if (h !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_asid_cleared: got %b expected 0", h); end
    do_lookup(20'h00101, 9'd7, v, h, p);
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_asid_global_kept: got %b expected 1", h); end
    do_lookup(20'h12345, 9'd3, v, h, p);
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_asid_other_kept: got %b expected 1", h); end
    do_lookup(20'h00303, 9'd5, v, h, p);
    tests_run++; if (h !== 1'b0) begin tests_failed++; $display("[TB] FAIL walk_fill_dropped: got %b expected 0", h); end
  endtask

  task automatic test_flush_va();
    logic v, h, busy, rh; pte_t p; int cyc;
    do_flush(1'b0, 9'd0, 1'b1, 20'h12345, 1'b0, 1'b0, 20'h0, 9'd0, cyc, busy, rh);
    tests_run++; if (cyc != 1) begin tests_failed++; $display("[TB] FAIL flush_va_cycles: got %0d expected 1", cyc); end
    do_lookup(20'h12345, 9'd3, v, h, p);
    tests_run++; if (h !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_va_cleared: got %b expected 0", h); end
    do_lookup(20'h0ABCD, 9'd3, v, h, p);
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_va_neighbour_kept: got %b expected 1", h); end
  endtask

  task automatic test_flush_with_lookup();
    logic v, h, busy, rh; pte_t p; int cyc;
    do_fill(20'h00505, 9'd4, mk_pte(22'h00505, 1'b0));
    do_flush(1'b0, 9'd0, 1'b0, 20'h0, 1'b0, 1'b1, 20'h00505, 9'd4, cyc, busy, rh);
    tests_run++; if (rh !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_lookup_preflush: got %b expected 1", rh); end
    tests_run++; if (cyc != 4) begin tests_failed++; $display("[TB] FAIL flush_full_cycles: got %0d expected 4", cyc); end
    do_lookup(20'h00505, 9'd4, v, h, p);
    tests_run++; if (h !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_full_cleared: got %b expected 0", h); end
    do_lookup(20'h00101, 9'd7, v, h, p);
    tests_run++; if (h !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_full_global_cleared: got %b expected 0", h); end
  endtask

  task automatic test_reset_mid_walk();
    logic v, h; pte_t p;
    do_fill(20'h00606, 9'd4, mk_pte(22'h00606, 1'b0));
    @(negedge clk);
    flush_valid = 1'b1; flush_asid_en = 1'b0; flush_va_en = 1'b0;
    @(negedge clk);
    flush_valid = 1'b0;
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL midwalk_busy: got %b expected 0", req_ready); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1 || flush_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midwalk_reset_idle: got req_ready=%b flush_ready=%b expected 1 1", req_ready, flush_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    do_lookup(20'h00606, 9'd4, v, h, p);
    tests_run++; if (h !== 1'b0) begin tests_failed++; $display("[TB] FAIL midwalk_reset_cleared: got %b expected 0", h); end
  endtask

  task automatic test_superpage();
    pte_t sp;
    sp = mk_pte(22'h0, 1'b0);
    sp.ppn1 = 12'hABC;
    sp.ppn0 = 10'h055;
    @(negedge clk);
    sp_fill_valid = 1'b1; sp_fill_vpn = {10'h155, 10'h000}; sp_fill_pte = sp;
    @(negedge clk);
    sp_fill_valid = 1'b0;
    @(negedge clk);
    sp_req_valid = 1'b1; sp_req_vpn = {10'h155, 10'h3FF};
    @(negedge clk);
    sp_req_valid = 1'b0;
    tests_run++; if (sp_resp_hit !== 1'b1) begin tests_failed++; $display("[TB] FAIL super_hit: got %b expected 1", sp_resp_hit); end
    tests_run++; if ({sp_resp_pte.ppn1, sp_resp_pte.ppn0} !== 22'h2AF3FF) begin tests_failed++; $display("[TB] FAIL super_ppn: got %h expected 2af3ff", {sp_resp_pte.ppn1, sp_resp_pte.ppn0}); end
    @(negedge clk);
    sp_req_valid = 1'b1; sp_req_vpn = {10'h154, 10'h000};
    @(negedge clk);
    sp_req_valid = 1'b0;
    tests_run++; if (sp_resp_valid !== 1'b1 || sp_resp_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL super_other_vpn1: got valid=%b hit=%b expected 1 0", sp_resp_valid, sp_resp_hit); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_plru();
    test_global();
    test_refill();
    test_flush_asid();
    test_flush_va();
    test_flush_with_lookup();
    test_reset_mid_walk();
    test_superpage();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
